// File: rtl/demux5_reg.sv
`default_nettype none
// ============================================================================
// Module      : demux5_reg
// Description : Registered 1-to-5 demultiplexer with per-lane valid/ready
//               handshake. Select values 5..7 discard the item and bump a
//               saturating 8-bit drop counter. Defining DEMUX5_AUTO_EN
//               replaces the select input with a round-robin lane pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module demux5_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  input  logic         d_valid,
  output logic         d_ready,
  input  logic [2:0]   s,
  output logic [W-1:0] y0,
  output logic [W-1:0] y1,
  output logic [W-1:0] y2,
  output logic [W-1:0] y3,
  output logic [W-1:0] y4,
  output logic [4:0]   v,
  input  logic [4:0]   r,
  output logic [7:0]   drop_cnt
);

  localparam int         N_LANES   = 5;
  localparam logic [7:0] C_CNT_MAX = 8'hFF;
  localparam logic [2:0] C_LAST    = 3'd4;

  logic [2:0]         w_tgt;      // lane the current offer is aimed at
  logic [4:0]         w_sel;      // one-hot decode of w_tgt; all-zero means drop
  logic               w_lane_ok;  // target is a real lane
  logic               w_room;     // selected lane can take an item this cycle
  logic               w_accept;
  logic               w_drop;
  logic [4:0]         w_v;
  logic [W-1:0]       w_y [N_LANES];
  logic [7:0]         r_cnt;

`ifdef DEMUX5_AUTO_EN
  logic [2:0] r_ptr;
  logic       w_unused_s;

  // s has no role when the pointer picks the lane
  assign w_unused_s = ^s;

  // Round-robin pointer: advances only on an accepted item, wraps 4 -> 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (w_accept) begin
      r_ptr <= (r_ptr == C_LAST) ? 3'd0 : r_ptr + 3'd1;
    end
  end

  assign w_tgt = r_ptr;
`else
  assign w_tgt = s;
`endif

  // A lane has room when empty or when it is being drained this same edge
  assign w_lane_ok = |w_sel;
  assign w_room    = |(w_sel & (~w_v | r));
  assign d_ready   = w_lane_ok ? w_room : 1'b1;
  assign w_accept  = d_valid & d_ready;
  assign w_drop    = w_accept & ~w_lane_ok;

  for (genvar k = 0; k < N_LANES; k++) begin : g_lane
    logic         r_full;
    logic [W-1:0] r_data;
    logic         w_load;
    logic         w_drain;

    assign w_sel[k] = (w_tgt == 3'(k));
    assign w_load   = w_accept & w_sel[k];
    assign w_drain  = r_full & r[k];

    // Lane register: a load wins over a simultaneous drain so nothing is lost
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_full <= 1'b0;
        r_data <= '0;
      end else if (w_load) begin
        r_full <= 1'b1;
        r_data <= d;
      end else if (w_drain) begin
        r_full <= 1'b0;
        r_data <= '0;
      end
    end

    assign w_v[k] = r_full;
    assign w_y[k] = r_data;
  end

  // Drop counter saturates at 255 instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_drop && (r_cnt != C_CNT_MAX)) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign v        = w_v;
  assign y0       = w_y[0];
  assign y1       = w_y[1];
  assign y2       = w_y[2];
  assign y3       = w_y[3];
  assign y4       = w_y[4];
  assign drop_cnt = r_cnt;

endmodule
`default_nettype wire
